// File: rtl/l2_arb_pkg.sv
// Shared types and default widths for the L2 port arbiter.
// The round-robin grant policy is enabled with L2_ARB_ROUND_ROBIN_EN.
package l2_arb_pkg;

    localparam int unsigned L2_ADDR_W = 32;
    localparam int unsigned L2_LINE_W = 256;

    typedef enum logic [1:0] {
        IDLE,
        SERVE_I,
        SERVE_D,
        RELEASE
    } arb_state_t;

    typedef enum logic {
        REQ_I,
        REQ_D
    } requester_t;

endpackage

// File: rtl/l2_arb_grant.sv
// Grant picker for the L2 arbiter: fixed D priority by default, or alternating
// round-robin on contention when L2_ARB_ROUND_ROBIN_EN is defined.
module l2_arb_grant
    import l2_arb_pkg::*;
(
`ifdef L2_ARB_ROUND_ROBIN_EN
    input  logic clk,
    input  logic reset,
`endif
    input  logic i_req,
    input  logic d_req,
    input  logic enable,
    output logic grant,
    output logic valid
);

    requester_t grant_sel;

`ifdef L2_ARB_ROUND_ROBIN_EN
    requester_t last_grant;

    // Starts at D so the first contested grant after reset goes to I.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= REQ_D;
        end else if (valid) begin
            last_grant <= grant_sel;
        end
    end
`endif

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        grant_sel = REQ_D;
        if (i_req && !d_req) begin
            grant_sel = REQ_I;
        end else if (i_req && d_req) begin
`ifdef L2_ARB_ROUND_ROBIN_EN
            grant_sel = (last_grant == REQ_D) ? REQ_I : REQ_D;
`else
            grant_sel = REQ_D;
`endif
        end
    end

    assign valid = enable && (i_req || d_req);
    assign grant = (grant_sel == REQ_D);

endmodule

// File: rtl/l2_arbiter.sv
// Shares the unified L2 port between the L1 I-miss and D-miss paths.
// Define L2_ARB_ROUND_ROBIN_EN for alternating grants on contention.
module l2_arbiter
    import l2_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = L2_ADDR_W,
    parameter int unsigned LINE_W = L2_LINE_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              l2_read,
    output logic              l2_write,
    output logic [ADDR_W-1:0] l2_address,
    output logic [LINE_W-1:0] l2_wdata,
    input  logic [LINE_W-1:0] l2_rdata,
    input  logic              l2_resp
);

    arb_state_t state, state_next;
    logic       op_write;
    logic       grant_d;
    logic       grant_valid;

    l2_arb_grant u_grant (
`ifdef L2_ARB_ROUND_ROBIN_EN
        .clk    (clk),
        .reset  (reset),
`endif
        .i_req  (i_read),
        .d_req  (d_read || d_write),
        .enable (state == IDLE),
        .grant  (grant_d),
        .valid  (grant_valid)
    );

    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (grant_valid) state_next = grant_d ? SERVE_D : SERVE_I;
            SERVE_I: if (l2_resp) state_next = RELEASE;
            SERVE_D: if (l2_resp) state_next = RELEASE;
            RELEASE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Request parameters are captured on the grant edge; both-read-and-write is a write.
    always_ff @(posedge clk) begin
        // NOTE: the transaction latch is a handful of flops, not a memory, so it is reset to 0.
        if (reset) begin
            l2_address <= '0;
            l2_wdata   <= '0;
            op_write   <= 1'b0;
        end else if (grant_valid) begin
            l2_address <= grant_d ? d_address : i_address;
            l2_wdata   <= d_wdata;
            op_write   <= grant_d && d_write;
        end
    end

    always_comb begin
        l2_read  = 1'b0;
        l2_write = 1'b0;
        i_resp   = 1'b0;
        d_resp   = 1'b0;
        i_rdata  = '0;
        d_rdata  = '0;
        unique case (state)
            SERVE_I: begin
                l2_read  = !op_write;
                l2_write = op_write;
                i_resp   = l2_resp;
                i_rdata  = l2_rdata;
            end
            SERVE_D: begin
                l2_read  = !op_write;
                l2_write = op_write;
                d_resp   = l2_resp;
                d_rdata  = l2_rdata;
            end
            default: ;
        endcase
    end

endmodule
